multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : multicycle_ctrl
// Description : Main control FSM of a multicycle RISC-V subset core with a
//               bounded memory-wait timeout.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOP,
   output logic [1:0] ImmSrc,
   output logic       illegal,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam int            CW          = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] c_WAIT_LAST = CW'(WAIT_MAX - 1);
   localparam logic [6:0]    c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0]    c_OP_STORE  = 7'b0100011;
   localparam logic [6:0]    c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0]    c_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0]    c_OP_JAL    = 7'b1101111;
   localparam logic [6:0]    c_OP_BEQ    = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic          w_waiting;
   logic          w_timeout;

   assign state     = r_state;
   assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE)) && !mem_ready;
   assign w_timeout = w_waiting && (r_cnt == c_WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         // A timeout restarts the wait window even when FETCH re-enters itself
         if ((w_next != r_state) || w_timeout)
            r_cnt <= '0;
         else if (w_waiting)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   always_comb begin
      w_next    = r_state;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOP     = 2'b00;
      ImmSrc    = 2'b00;
      illegal   = 1'b0;
      mem_err   = 1'b0;
      case (r_state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
            case (opcode)
               c_OP_LOAD, c_OP_STORE: w_next = S_MEMADR;
               c_OP_RTYPE:            w_next = S_EXECR;
               c_OP_ITYPE:            w_next = S_EXECI;
               c_OP_JAL:              w_next = S_JAL;
               c_OP_BEQ:              w_next = S_BEQ;
               default: begin
                  w_next  = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            if (opcode == c_OP_STORE) begin
               ImmSrc = 2'b01;
               w_next = S_MEMWRITE;
            end else begin
               w_next = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            w_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOP   = 2'b10;
            w_next  = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOP   = 2'b10;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            w_next   = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ImmSrc  = 2'b11;
            PCWrite = 1'b1;
            w_next  = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOP   = 2'b01;
            ImmSrc  = 2'b10;
            PCWrite = zero;
            w_next  = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
      // Timeout suppresses architectural writes but leaves the write strobe alone
      if (w_timeout) begin
         mem_err  = 1'b1;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         w_next   = S_FETCH;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_multicycle_ctrl
// Description : Directed scenarios plus randomized instruction streams for
//               multicycle_ctrl, checked against a per-instruction trace model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int WM = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal, mem_err;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOP, ImmSrc;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         mr;
      logic [3:0] st;
      bit         pcw, adr, irw, memw, regw, ill, merr;
      logic [1:0] rs, sa, sb, aop, imm;
   } exp_t;

   exp_t q[$];

   multicycle_ctrl #(.WAIT_MAX(WM)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .ImmSrc(ImmSrc), .illegal(illegal),
      .mem_err(mem_err), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   function automatic exp_t blank(input logic [3:0] st, input bit mr);
      exp_t t;
      t.mr = mr; t.st = st;
      t.pcw = 0; t.adr = 0; t.irw = 0; t.memw = 0; t.regw = 0; t.ill = 0; t.merr = 0;
      t.rs = 0; t.sa = 0; t.sb = 0; t.aop = 0; t.imm = 0;
      return t;
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   // Expected per-cycle trace of one instruction: fetch stalls, fixed phases, memory stalls
   task automatic build(input logic [6:0] op, input bit z, input int wf, input int wm);
      exp_t t;
      bit   aborted = 0;
      for (int k = 1; k <= wf; k++) begin
         t = blank(0, 0); t.sb = 2; t.rs = 2; t.merr = (k == WM); q.push_back(t);
      end
      t = blank(0, 1); t.sb = 2; t.rs = 2; t.irw = 1; t.pcw = 1; q.push_back(t);
      t = blank(1, rb()); t.sa = 1; t.sb = 1; t.imm = 2;
      t.ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100011});
      q.push_back(t);
      case (op)
         7'b0110011, 7'b0010011, 7'b1101111: begin
            if (op == 7'b0110011) begin
               t = blank(6, rb()); t.sa = 2; t.aop = 2;
            end else if (op == 7'b0010011) begin
               t = blank(8, rb()); t.sa = 2; t.sb = 1; t.aop = 2;
            end else begin
               t = blank(9, rb()); t.sa = 1; t.sb = 2; t.imm = 3; t.pcw = 1;
            end
            q.push_back(t);
            t = blank(7, rb()); t.regw = 1; q.push_back(t);
         end
         7'b1100011: begin
            t = blank(10, rb()); t.sa = 2; t.aop = 1; t.imm = 2; t.pcw = z; q.push_back(t);
         end
         7'b0000011, 7'b0100011: begin
            t = blank(2, rb()); t.sa = 2; t.sb = 1; t.imm = (op == 7'b0100011) ? 2'd1 : 2'd0;
            q.push_back(t);
            for (int k = 1; k <= wm && !aborted; k++) begin
               t = blank((op == 7'b0100011) ? 4'd5 : 4'd3, 0);
               t.adr = 1; t.memw = (op == 7'b0100011); t.merr = (k == WM);
               q.push_back(t);
               if (k == WM) aborted = 1;
            end
            if (!aborted) begin
               t = blank((op == 7'b0100011) ? 4'd5 : 4'd3, 1);
               t.adr = 1; t.memw = (op == 7'b0100011); q.push_back(t);
               if (op == 7'b0000011) begin
                  t = blank(4, rb()); t.rs = 1; t.regw = 1; q.push_back(t);
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic test_reset();
      opcode = 7'h7F;
      rst = 1'b1;
      mem_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      checks++;
      if ({state, IRWrite, PCWrite, illegal, mem_err, MemWrite, RegWrite, ALUSrcB, ResultSrc, ALUSrcA, AdrSrc}
          !== {4'd0, 6'b0, 2'b10, 2'b10, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: state=%0d irw=%b pcw=%b ill=%b merr=%b srcb=%b rs=%b expected state=0 strobes=0 srcb=10 rs=10",
                  state, IRWrite, PCWrite, illegal, mem_err, ALUSrcB, ResultSrc);
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({IRWrite, PCWrite, mem_err} !== 3'b110) begin
         errors++;
         $display("FAIL reset_fetch_ready: irw=%b pcw=%b merr=%b expected 1 1 0", IRWrite, PCWrite, mem_err);
      end
   endtask

   task automatic test_add();
      logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      do_reset();
      opcode = 7'b0110011;
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (state !== exp_st[i] || RegWrite !== (exp_st[i] == 4'd7) ||
             (exp_st[i] == 4'd6 && ALUOP !== 2'b10)) begin
            errors++;
            $display("FAIL add_seq[%0d]: state=%0d regw=%b aluop=%b expected state=%0d", i, state, RegWrite, ALUOP, exp_st[i]);
         end
         tick();
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      bit         mr     [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      do_reset();
      opcode = 7'b0000011;
      for (int i = 0; i < 9; i++) begin
         mem_ready = mr[i];
         #1;
         checks++;
         if (state !== exp_st[i] || mem_err !== 1'b0 ||
             (exp_st[i] == 4'd4 && {ResultSrc, RegWrite} !== 3'b011)) begin
            errors++;
            $display("FAIL lw_seq[%0d]: state=%0d rs=%b regw=%b merr=%b expected state=%0d", i, state, ResultSrc, RegWrite, mem_err, exp_st[i]);
         end
         tick();
      end
   endtask

   task automatic test_beq(input bit z);
      logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
      do_reset();
      opcode = 7'b1100011;
      zero = z;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (state !== exp_st[i] || (exp_st[i] == 4'd10 && PCWrite !== z)) begin
            errors++;
            $display("FAIL beq_z%0d[%0d]: state=%0d pcw=%b expected state=%0d pcw=%b", z, i, state, PCWrite, exp_st[i], z);
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd0};
      do_reset();
      opcode = 7'b1111111;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (state !== exp_st[i] || illegal !== (i == 1) || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL illegal[%0d]: state=%0d ill=%b regw=%b memw=%b expected state=%0d ill=%b",
                     i, state, illegal, RegWrite, MemWrite, exp_st[i], i == 1);
         end
         tick();
      end
   endtask

   task automatic test_sw_timeout();
      do_reset();
      opcode = 7'b0100011;
      mem_ready = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (state !== 4'd2 || ImmSrc !== 2'b01) begin
         errors++;
         $display("FAIL sw_memadr: state=%0d imm=%b expected 2 01", state, ImmSrc);
      end
      tick();
      mem_ready = 1'b0;
      for (int k = 1; k <= WM; k++) begin
         #1;
         checks++;
         if (state !== 4'd5 || MemWrite !== 1'b1 || mem_err !== (k == WM)) begin
            errors++;
            $display("FAIL sw_wait[%0d]: state=%0d memw=%b merr=%b expected 5 1 %b", k, state, MemWrite, mem_err, k == WM);
         end
         tick();
      end
      #1;
      checks++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL sw_after_timeout: state=%0d memw=%b merr=%b expected 0 0 0", state, MemWrite, mem_err);
      end
   endtask

   task automatic test_reset_memwrite();
      do_reset();
      opcode = 7'b0100011;
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (state !== 4'd5 || MemWrite !== 1'b1) begin
         errors++;
         $display("FAIL rst_mw_before: state=%0d memw=%b expected 5 1", state, MemWrite);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || mem_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mw_after: state=%0d memw=%b merr=%b expected 0 0 0", state, MemWrite, mem_err);
      end
      // A cleared counter means the FETCH timeout lands on exactly the WM-th stall
      for (int k = 1; k <= WM; k++) begin
         #1;
         checks++;
         if (mem_err !== (k == WM)) begin
            errors++;
            $display("FAIL rst_mw_count[%0d]: merr=%b expected %b", k, mem_err, k == WM);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1101111, 7'b1100011, 7'b0000000};
      exp_t       t;
      logic [20:0] got, want;
      do_reset();
      for (int n = 0; n < 80; n++) begin
         logic [6:0] op;
         bit         z;
         op = ops[$urandom_range(0, 6)];
         if (op == 7'b0000000) op = 7'($urandom_range(0, 127));
         z  = rb();
         q.delete();
         build(op, z, $urandom_range(0, WM), $urandom_range(0, WM + 1));
         opcode = op;
         zero = z;
         while (q.size() > 0) begin
            t = q.pop_front();
            mem_ready = t.mr;
            #1;
            got  = {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal, mem_err,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOP, ImmSrc};
            want = {t.st, t.pcw, t.adr, t.irw, t.memw, t.regw, t.ill, t.merr,
                    t.rs, t.sa, t.sb, t.aop, t.imm};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL random[%0d] op=%b: got=%h expected=%h (state %0d vs %0d)", n, op, got, want, state, t.st);
            end
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_beq(1'b1);
      test_beq(1'b0);
      test_illegal();
      test_sw_timeout();
      test_reset_memwrite();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
